hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the PC write enable, the IF_ID write and flush controls, and the ID_EX bubble select. It resolves load-use hazards, taken-branch redirects, instruction-memory wait states and the structural hazard on the multi-cycle mult/div unit, and it counts stall cycles for performance reporting. It sits beside IF_ID and ID_EX; it holds no datapath values itself.

---
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and sequencing controller for the 5-stage MIPS pipeline. Decides,
//   every cycle, whether the PC and IF_ID load, whether IF_ID is replaced by a
//   NOP and whether ID_EX receives a bubble. It resolves load-use hazards,
//   taken-branch redirects, instruction-memory wait states and the structural
//   hazard on the multi-cycle mult/div unit, and counts stall cycles.
//
// Parameters
//   MULDIV_LAT  cycles the mult/div unit stays busy after issue (>= 1)
//   CNT_W       width of the saturating stall counter
//
// Ports
//   i_clk              pipeline clock, rising edge
//   i_reset            asynchronous, active-high reset
//   i_id_rs/i_id_rt    source registers of the instruction in ID
//   i_id_use_rs/_rt    the ID instruction really reads rs / rt
//   i_id_is_muldiv     ID instruction is mult/multu/div/divu
//   i_id_reads_hilo    ID instruction is mfhi/mflo
//   i_ex_rd            destination register of the instruction in EX
//   i_ex_mem_read      EX instruction is a load
//   i_ex_branch_taken  branch/jump resolved taken in EX this cycle
//   i_imem_ready       instruction memory returns valid data this cycle
//   o_pc_write         PC load enable
//   o_if_id_write      IF_ID load enable (0 = hold)
//   o_if_id_flush      IF_ID loads a NOP instead of fetched data
//   o_id_ex_bubble     ID_EX loads an all-zero control bundle
//   o_muldiv_busy      mult/div unit occupied
//   o_stall_count      saturating count of cycles with o_if_id_write = 0
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_use_rs,
    input  logic             i_id_use_rt,
    input  logic             i_id_is_muldiv,
    input  logic             i_id_reads_hilo,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_branch_taken,
    input  logic             i_imem_ready,
    output logic             o_pc_write,
    output logic             o_if_id_write,
    output logic             o_if_id_flush,
    output logic             o_id_ex_bubble,
    output logic             o_muldiv_busy,
    output logic [CNT_W-1:0] o_stall_count
);

    localparam int BUSY_W = $clog2(MULDIV_LAT + 1);

    typedef enum logic {
        ST_RUN,
        ST_MULDIV
    } state_t;

    state_t              r_state;
    logic [BUSY_W-1:0]   r_busy_cnt;
    logic [CNT_W-1:0]    r_stall_count;

    logic w_load_use;
    logic w_struct_haz;
    logic w_stall;
    logic w_issue;

    // A load writing $0 never creates a real dependency.
    assign w_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                        ((i_id_use_rs && (i_id_rs == i_ex_rd)) ||
                         (i_id_use_rt && (i_id_rt == i_ex_rd)));

    assign w_struct_haz = (r_state == ST_MULDIV) && (i_id_is_muldiv || i_id_reads_hilo);
    assign w_stall      = w_load_use || w_struct_haz;
    assign w_issue      = i_id_is_muldiv && !w_stall && !i_ex_branch_taken && !i_reset;

    assign o_muldiv_busy = (r_state == ST_MULDIV);
    assign o_stall_count = r_stall_count;

    // Priority: reset, branch redirect, stall, imem wait, normal flow.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_pc_write     = 1'b1;
        o_if_id_write  = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b0;
        if (i_reset) begin
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_if_id_flush  = 1'b1;
            o_id_ex_bubble = 1'b1;
        end else if (i_ex_branch_taken) begin
            // Redirect wins over any stall: the stalled instructions are squashed anyway.
            o_if_id_flush  = 1'b1;
            o_id_ex_bubble = 1'b1;
        end else if (w_stall) begin
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_id_ex_bubble = 1'b1;
        end else if (!i_imem_ready) begin
            // Older instruction advances; a NOP fills ID while fetch waits.
            o_pc_write     = 1'b0;
            o_if_id_flush  = 1'b1;
        end
    end

    // Mult/div occupancy. A taken branch does not cancel the operation in
    // flight: it is older than the branch and must complete.
    always_ff @(posedge i_clk or posedge i_reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (i_reset) begin
            r_state    <= ST_RUN;
            r_busy_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_issue) begin
                        r_state    <= ST_MULDIV;
                        r_busy_cnt <= BUSY_W'(MULDIV_LAT);
                    end
                end
                ST_MULDIV: begin
                    if (r_busy_cnt == BUSY_W'(1)) begin
                        r_state    <= ST_RUN;
                        r_busy_cnt <= '0;
                    end else begin
                        r_busy_cnt <= r_busy_cnt - BUSY_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_busy_cnt <= '0;
                end
            endcase
        end
    end

    // Counts held-fetch cycles; sticks at all-ones instead of wrapping.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_count <= '0;
        end else if (!o_if_id_write && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl. A behavioural model tracks the cycle
//   of the last mult/div issue and a plain integer stall count; a compare
//   process checks every output on every falling edge. Directed sequences pin
//   the model with literal expectations, then a randomized phase follows.
//   A second instance with CNT_W=4 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        use_rs, use_rt, is_muldiv, reads_hilo;
    logic        mem_read, br_taken, imem_ready;

    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, muldiv_busy;
    logic [15:0] stall_count;
    logic        pc_write4, if_id_write4, if_id_flush4, id_ex_bubble4, muldiv_busy4;
    logic [3:0]  stall_count4;

    int n_vec  = 0;
    int n_fail = 0;

    hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(16)) u_dut (
        .i_clk(clk), .i_reset(rst),
        .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_use_rs(use_rs), .i_id_use_rt(use_rt),
        .i_id_is_muldiv(is_muldiv), .i_id_reads_hilo(reads_hilo),
        .i_ex_rd(ex_rd), .i_ex_mem_read(mem_read),
        .i_ex_branch_taken(br_taken), .i_imem_ready(imem_ready),
        .o_pc_write(pc_write), .o_if_id_write(if_id_write),
        .o_if_id_flush(if_id_flush), .o_id_ex_bubble(id_ex_bubble),
        .o_muldiv_busy(muldiv_busy), .o_stall_count(stall_count)
    );

    hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(4)) u_dut4 (
        .i_clk(clk), .i_reset(rst),
        .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_use_rs(use_rs), .i_id_use_rt(use_rt),
        .i_id_is_muldiv(is_muldiv), .i_id_reads_hilo(reads_hilo),
        .i_ex_rd(ex_rd), .i_ex_mem_read(mem_read),
        .i_ex_branch_taken(br_taken), .i_imem_ready(imem_ready),
        .o_pc_write(pc_write4), .o_if_id_write(if_id_write4),
        .o_if_id_flush(if_id_flush4), .o_id_ex_bubble(id_ex_bubble4),
        .o_muldiv_busy(muldiv_busy4), .o_stall_count(stall_count4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        use_rs = 1'b0; use_rt = 1'b0; is_muldiv = 1'b0; reads_hilo = 1'b0;
        mem_read = 1'b0; br_taken = 1'b0; imem_ready = 1'b1;
    endtask

    task automatic set_load_use();
        mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; use_rs = 1'b1;
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model + compare process ----------------
    bit running = 1'b0;
    int cyc = 0;
    int issue_cyc = 0;
    bit have_issue = 1'b0;
    int m_count = 0;
    int m_count4 = 0;

    always @(negedge clk) begin
        if (running) begin
            bit busy, lu, st, e_pc, e_wr, e_fl, e_bb;
            if (rst) begin
                have_issue = 1'b0;
                m_count    = 0;
                m_count4   = 0;
                busy = 1'b0;
                e_pc = 1'b0; e_wr = 1'b0; e_fl = 1'b1; e_bb = 1'b1;
            end else begin
                // Busy during the LAT cycles that follow the issue cycle.
                busy = have_issue && (cyc > issue_cyc) && (cyc <= issue_cyc + LAT);
                lu   = mem_read && (ex_rd != 0) &&
                       ((use_rs && id_rs == ex_rd) || (use_rt && id_rt == ex_rd));
                st   = lu || (busy && (is_muldiv || reads_hilo));
                if (br_taken)         begin e_pc = 1; e_wr = 1; e_fl = 1; e_bb = 1; end
                else if (st)          begin e_pc = 0; e_wr = 0; e_fl = 0; e_bb = 1; end
                else if (!imem_ready) begin e_pc = 0; e_wr = 1; e_fl = 1; e_bb = 0; end
                else                  begin e_pc = 1; e_wr = 1; e_fl = 0; e_bb = 0; end
            end
            check("pc_write",     32'(pc_write),     32'(e_pc));
            check("if_id_write",  32'(if_id_write),  32'(e_wr));
            check("if_id_flush",  32'(if_id_flush),  32'(e_fl));
            check("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bb));
            check("muldiv_busy",  32'(muldiv_busy),  32'(busy));
            check("stall_count",  32'(stall_count),  32'(m_count));
            check("stall_count4", 32'(stall_count4), 32'(m_count4));
            check("muldiv_busy4", 32'(muldiv_busy4), 32'(busy));
            if (!rst) begin
                if (!e_wr) begin
                    if (m_count  < 65535) m_count++;
                    if (m_count4 < 15)    m_count4++;
                end
                if (is_muldiv && !st && !br_taken) begin
                    issue_cyc  = cyc;
                    have_issue = 1'b1;
                end
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        idle();
        rst = 1'b1;
        running = 1'b1;
        tick();
        check("rst_flush_lit", 32'(if_id_flush), 32'd1);
        check("rst_count_lit", 32'(stall_count), 32'd0);
        tick();
        rst = 1'b0;

        // Single load-use hazard: one stall cycle.
        set_load_use();
        #1 check("lu_pc_lit", 32'(pc_write), 32'd0);
        check("lu_bubble_lit", 32'(id_ex_bubble), 32'd1);
        tick();
        check("lu_count_lit", 32'(stall_count), 32'd1);
        idle();
        // Same pattern against $0 never stalls.
        mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; use_rs = 1'b1;
        #1 check("lu_r0_lit", 32'(if_id_write), 32'd1);
        tick();
        check("lu_r0_count_lit", 32'(stall_count), 32'd1);
        idle();

        // mult in ID at cycle 0, mfhi in ID from cycle 1.
        is_muldiv = 1'b1;
        tick();
        is_muldiv = 1'b0; reads_hilo = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            #1 check("mfhi_busy_lit", 32'(muldiv_busy), 32'd1);
            check("mfhi_hold_lit", 32'(if_id_write), 32'd0);
            tick();
        end
        #1 check("mfhi_go_lit", 32'(if_id_write), 32'd1);
        check("mfhi_idle_lit", 32'(muldiv_busy), 32'd0);
        tick();
        check("mfhi_count_lit", 32'(stall_count), 32'd5);
        idle();

        // Branch overrides a simultaneous load-use stall.
        set_load_use();
        br_taken = 1'b1;
        #1 check("br_pc_lit", 32'(pc_write), 32'd1);
        check("br_flush_lit", 32'(if_id_flush), 32'd1);
        tick();
        check("br_count_lit", 32'(stall_count), 32'd5);
        idle();

        // Taken branch at busy cycle 2 does not cancel MULDIV.
        is_muldiv = 1'b1;
        tick();
        is_muldiv = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            br_taken = (i == 2);
            #1 check("brmd_busy_lit", 32'(muldiv_busy), 32'd1);
            tick();
        end
        br_taken = 1'b0;
        #1 check("brmd_done_lit", 32'(muldiv_busy), 32'd0);
        tick();

        // Three instruction-memory wait cycles.
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("imem_pc_lit", 32'(pc_write), 32'd0);
            check("imem_write_lit", 32'(if_id_write), 32'd1);
            tick();
        end
        check("imem_count_lit", 32'(stall_count), 32'd5);
        idle();

        // Asynchronous reset between edges during MULDIV.
        is_muldiv = 1'b1;
        tick();
        is_muldiv = 1'b0;
        #2 rst = 1'b1;
        #1 check("arst_busy_lit", 32'(muldiv_busy), 32'd0);
        check("arst_count_lit", 32'(stall_count), 32'd0);
        tick();
        rst = 1'b0;
        is_muldiv = 1'b1;
        #1 check("arst_issue_lit", 32'(pc_write), 32'd1);
        tick();
        is_muldiv = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            #1 check("arst_win_lit", 32'(muldiv_busy), 32'd1);
            tick();
        end
        #1 check("arst_end_lit", 32'(muldiv_busy), 32'd0);
        tick();

        // Twenty stall cycles: the 4-bit counter saturates at 15.
        set_load_use();
        repeat (20) tick();
        idle();
        check("sat16_lit", 32'(stall_count), 32'd20);
        check("sat4_lit", 32'(stall_count4), 32'd15);

        // Randomized phase.
        for (int n = 0; n < 3000; n++) begin
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            ex_rd      = 5'($urandom_range(0, 3));
            use_rs     = ($urandom_range(0, 99) < 60);
            use_rt     = ($urandom_range(0, 99) < 40);
            mem_read   = ($urandom_range(0, 99) < 30);
            is_muldiv  = ($urandom_range(0, 99) < 15);
            reads_hilo = ($urandom_range(0, 99) < 20);
            br_taken   = ($urandom_range(0, 99) < 8);
            imem_ready = ($urandom_range(0, 99) < 80);
            rst        = ($urandom_range(0, 999) < 8);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
        @(negedge clk);
        #1 running = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
